// File: rtl/imem_line_fetch.sv
// Instruction-memory line fetcher: serves 16-byte cache line fills from an
// internal word store, one word per cycle, with a preload write port.
module imem_line_fetch #(
  parameter int ADDR_BITS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ireq,
  input  logic [31:0]  iaddr,
  input  logic         iwe,
  input  logic [31:0]  iwaddr,
  input  logic [31:0]  iwdata,
  output logic         obusy,
  output logic         ovalid,
  output logic [127:0] oline,
  output logic [31:0]  oaddr
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_READ = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [27:0]     base_q, base_d;
  logic [2:0][31:0] lane_q, lane_d;
  logic [127:0]    oline_q, oline_d;
  logic [31:0]     oaddr_q, oaddr_d;
  logic            ovalid_q, ovalid_d;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] rd_idx;
  logic [ADDR_BITS-1:0] wr_idx;
  logic [31:0]          rd_word;

  // Byte offset and address bits above the store size are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[3:0], iwaddr[31:ADDR_BITS+2], iwaddr[1:0]};

  // Line base is 16-byte aligned, so the counter supplies the low word-index bits.
  assign rd_idx  = {base_q[ADDR_BITS-3:0], cnt_q};
  assign wr_idx  = iwaddr[ADDR_BITS+1:2];
  assign rd_word = mem[rd_idx];

  // NOTE: the store has no reset term; preloaded programs survive rst, and a
  // reset loop over every word would defeat RAM inference.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking write means a capture at the same edge sees old data.
    if (iwe && !rst) begin
      mem[wr_idx] <= iwdata;
    end
  end

  always_comb begin
    // NOTE: every target gets a default first, so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    base_d   = base_q;
    lane_d   = lane_q;
    oline_d  = oline_q;
    oaddr_d  = oaddr_q;
    ovalid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ireq) begin
          state_d = S_READ;
          cnt_d   = 2'd0;
          base_d  = iaddr[31:4];
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Last word goes straight to the output so the line appears whole.
          oline_d  = {rd_word, lane_q};
          oaddr_d  = {base_q, 4'b0000};
          ovalid_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          lane_d[cnt_q] = rd_word;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      base_q   <= '0;
      lane_q   <= '0;
      oline_q  <= '0;
      oaddr_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      lane_q   <= lane_d;
      oline_q  <= oline_d;
      oaddr_q  <= oaddr_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign obusy  = (state_q == S_READ);
  assign ovalid = ovalid_q;
  assign oline  = oline_q;
  assign oaddr  = oaddr_q;

endmodule

// File: tb/tb_imem_line_fetch.sv
// Self-checking bench for imem_line_fetch: directed scenarios plus randomized
// fills compared against a word-array reference model.
module tb_imem_line_fetch;

  localparam int ADDR_BITS = 8;
  localparam int DEPTH     = 1 << ADDR_BITS;

  logic         clk = 1'b0;
  logic         rst;
  logic         ireq;
  logic [31:0]  iaddr;
  logic         iwe;
  logic [31:0]  iwaddr;
  logic [31:0]  iwdata;
  logic         obusy;
  logic         ovalid;
  logic [127:0] oline;
  logic [31:0]  oaddr;

  int n_checks = 0;
  int n_passed = 0;

  logic [31:0] mem_m [DEPTH];

  imem_line_fetch #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .ireq   (ireq),
    .iaddr  (iaddr),
    .iwe    (iwe),
    .iwaddr (iwaddr),
    .iwdata (iwdata),
    .obusy  (obusy),
    .ovalid (ovalid),
    .oline  (oline),
    .oaddr  (oaddr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_index(input logic [31:0] byte_addr);
    return int'((byte_addr >> 2) % DEPTH);
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] byte_addr);
    logic [127:0] line;
    logic [31:0]  base;
    base = byte_addr & ~32'hF;
    for (int k = 0; k < 4; k++) begin
      line[32*k +: 32] = mem_m[word_index(base + 32'(4 * k))];
    end
    return line;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    iwe    = 1'b1;
    iwaddr = addr;
    iwdata = data;
    step();
    iwe    = 1'b0;
    mem_m[word_index(addr)] = data;
  endtask

  // One fill of addr; optionally a loader write lands at edge E<wedge> (1..4).
  task automatic fill(input string tag, input logic [31:0] addr, input int wedge,
                      input logic [31:0] waddr, input logic [31:0] wdata);
    logic [127:0] old_line, new_line, exp_line, prev_oline, got_line;
    logic [31:0]  got_addr;
    int           lat;
    bit           early_change;

    old_line = model_line(addr);
    if (wedge > 0) mem_m[word_index(waddr)] = wdata;
    new_line = model_line(addr);
    // Lane k is read at E(k+1); a write at E_w is visible to it only if w <= k.
    for (int k = 0; k < 4; k++) begin
      exp_line[32*k +: 32] = (wedge > 0 && wedge <= k) ? new_line[32*k +: 32]
                                                        : old_line[32*k +: 32];
    end

    prev_oline = oline;
    ireq  = 1'b1;
    iaddr = addr;
    step();
    ireq  = 1'b0;
    iaddr = $urandom;
    check({tag, " busy after accept"}, 128'(obusy), 128'(1));

    lat          = -1;
    early_change = 1'b0;
    got_line     = '0;
    got_addr     = '0;
    for (int c = 1; c <= 8; c++) begin
      if (c == wedge) begin
        iwe    = 1'b1;
        iwaddr = waddr;
        iwdata = wdata;
      end
      step();
      iwe = 1'b0;
      if (ovalid) begin
        lat      = c;
        got_line = oline;
        got_addr = oaddr;
        break;
      end
      if (oline !== prev_oline) early_change = 1'b1;
    end
    check({tag, " latency"}, 128'(lat), 128'(4));
    check({tag, " no partial line"}, 128'(early_change), 128'(0));
    check({tag, " line"}, got_line, exp_line);
    check({tag, " base addr"}, 128'(got_addr), 128'({addr[31:4], 4'h0}));

    step();
    check({tag, " valid one cycle"}, 128'({ovalid, obusy}), 128'(0));
    check({tag, " line held"}, oline, exp_line);
  endtask

  initial begin
    int v_cnt;
    int v_cyc [2];
    logic [31:0]  v_addr [2];
    logic [127:0] v_line [2];
    logic [127:0] exp2;

    rst    = 1'b1;
    ireq   = 1'b0;
    iaddr  = '0;
    iwe    = 1'b0;
    iwaddr = '0;
    iwdata = '0;

    #3;
    check("reset outputs", {obusy, ovalid, oaddr, oline[95:0]}, '0);
    check("reset line", oline, '0);
    step();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) write_word(32'(4 * i), $urandom);

    // Basic fill
    write_word(32'h40, 32'h11111111);
    write_word(32'h44, 32'h22222222);
    write_word(32'h48, 32'h33333333);
    write_word(32'h4C, 32'h44444444);
    fill("basic", 32'h48, 0, 0, 0);
    check("basic literal", oline, 128'h44444444_33333333_22222222_11111111);

    // Alias: word 0x400 wraps onto word 0x000
    write_word(32'h000, 32'hDEADBEEF);
    fill("alias", 32'h400, 0, 0, 0);
    check("alias word0", 128'(oline[31:0]), 128'(32'hDEADBEEF));

    // Write collisions on lane 3 of line 0x40
    fill("wr before", 32'h40, 3, 32'h4C, 32'hAAAAAAAA);
    check("wr before lane3", 128'(oline[127:96]), 128'(32'hAAAAAAAA));
    write_word(32'h4C, 32'h44444444);
    fill("wr same", 32'h40, 4, 32'h4C, 32'hBBBBBBBB);
    check("wr same lane3", 128'(oline[127:96]), 128'(32'h44444444));
    write_word(32'h4C, 32'h44444444);

    // Busy drop: ireq held high, accepts only at E0 and E5
    v_cnt = 0;
    ireq  = 1'b1;
    iaddr = 32'h00;
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) iaddr = 32'h10;
      if (ovalid) begin
        if (v_cnt < 2) begin
          v_cyc[v_cnt]  = c;
          v_addr[v_cnt] = oaddr;
          v_line[v_cnt] = oline;
        end
        v_cnt++;
      end
    end
    ireq = 1'b0;
    check("b2b count", 128'(v_cnt), 128'(2));
    if (v_cnt >= 2) begin
      check("b2b first edge", 128'(v_cyc[0]), 128'(4));
      check("b2b period", 128'(v_cyc[1] - v_cyc[0]), 128'(5));
      check("b2b first addr", 128'(v_addr[0]), 128'(32'h00));
      check("b2b second addr", 128'(v_addr[1]), 128'(32'h10));
      exp2 = model_line(32'h10);
      check("b2b second line", v_line[1], exp2);
    end
    step();

    // Abort mid-fill with an async reset, requests/writes ignored during reset
    ireq  = 1'b1;
    iaddr = 32'h40;
    step();
    ireq = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    check("abort async", {obusy, ovalid, oaddr, oline[95:0]}, '0);
    check("abort line", oline, '0);
    ireq   = 1'b1;
    iaddr  = 32'h80;
    iwe    = 1'b1;
    iwaddr = 32'h40;
    iwdata = 32'h55555555;
    step();
    check("rst ignores ireq", 128'({obusy, ovalid}), 128'(0));
    ireq = 1'b0;
    iwe  = 1'b0;
    rst  = 1'b0;
    step();
    check("no valid after abort", 128'(ovalid), 128'(0));
    fill("after abort", 32'h40, 0, 0, 0);
    check("after abort literal", oline, 128'h44444444_33333333_22222222_11111111);

    // Randomized fills with optional overlapping loader writes
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wa;
      int we;
      a  = $urandom;
      we = int'($urandom_range(0, 4));
      wa = ($urandom_range(0, 1) == 1) ? ((a & ~32'hF) + 32'(4 * $urandom_range(0, 3)))
                                       : ($urandom & ~32'h3);
      if ($urandom_range(0, 2) == 0) write_word($urandom & ~32'h3, $urandom);
      fill($sformatf("rnd%0d", i), a, we, wa, $urandom);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_line_fetch.md
IMEM_LINE_FETCH -- requirements
Module: imem_line_fetch

Interface
REQ-001 Parameter: ADDR_BITS, 8, word-index width; backing store holds 2^ADDR_BITS 32-bit words.
REQ-002 Port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: ireq  input  1  line-fill request from instruction cache on miss.
REQ-005 Port: iaddr  input  32  byte address of missed instruction.
REQ-006 Port: iwe  input  1  loader write enable (program preload).
REQ-007 Port: iwaddr  input  32  loader byte address, word-aligned.
REQ-008 Port: iwdata  input  32  loader write data.
REQ-009 Port: obusy  output  1  fill in progress; requests ignored while high.
REQ-010 Port: ovalid  output  1  one-cycle pulse, oline/oaddr carry a completed line.
REQ-011 Port: oline  output  128  fetched 16-byte line.
REQ-012 Port: oaddr  output  32  byte base address of oline, low 4 bits zero.

Function
REQ-013 Storage SHALL be an internal word array indexed by addr[ADDR_BITS+1:2]; higher address bits SHALL be ignored (aliasing/wrap).
REQ-014 Loader write SHALL occur at rising edge when iwe=1, in any FSM state; storage is NOT cleared by reset.
REQ-015 FSM states: IDLE, READ; READ carries a 2-bit word counter cnt.
REQ-016 IDLE: at edge with ireq=1, latch base={iaddr[31:4],4'b0}, cnt=0, go READ, obusy=1 after that edge ("accept edge", E0).
REQ-017 READ: at edges E1..E4 capture word at base+4*cnt into lane cnt, cnt increments; lane k occupies oline[32k+31:32k] (word 0 in [31:0]).
REQ-018 At E4 (cnt==3): oline updated with full line, oaddr=base, ovalid=1, obusy=0, state IDLE.
REQ-019 ovalid SHALL be high for exactly one cycle (E4 to E5); fill latency accept-to-ovalid is 4 cycles.
REQ-020 oline and oaddr SHALL hold last completed line until next completion; partial lanes not visible on oline before E4.
REQ-021 ireq while obusy=1 SHALL be ignored (not queued); ireq at E5 SHALL be accepted, giving 5-cycle back-to-back period.
REQ-022 iaddr changes after accept edge SHALL NOT affect in-flight fill.
REQ-023 Simultaneous loader write and READ capture of same word at same edge: capture SHALL return old (pre-write) data.
REQ-024 Loader write to a not-yet-captured word of in-flight line SHALL be reflected in that line.
REQ-025 Request in same cycle as ovalid pulse is impossible from IDLE-only acceptance; no combinational path ireq->ovalid or ireq->obusy.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, cnt=0, obusy=0, ovalid=0, oline=0, oaddr=0, independent of clk.
REQ-027 rst asserted mid-fill SHALL abort fill with no ovalid pulse; first request after rst release restarts from word 0.
REQ-028 ireq and iwe SHALL be ignored while rst=1.

Verification
REQ-029 Reset: rst=1 mid-run -> obusy=0, ovalid=0, oline=0, oaddr=0 within same cycle, no clk needed.
REQ-030 Basic fill: preload words 0x40..0x4C = 0x11111111,0x22222222,0x33333333,0x44444444; ireq, iaddr=0x48 -> 4 cycles later ovalid=1, oaddr=0x40, oline=0x44444444_33333333_22222222_11111111.
REQ-031 Busy drop: ireq held high continuously, iaddr=0x00 then 0x10 -> fills at E0 and E5 only, ovalids 5 cycles apart, second oaddr=0x10 only if iaddr=0x10 at E5.
REQ-032 Alias: ADDR_BITS=8, preload 0x000=0xDEADBEEF, ireq iaddr=0x400 -> oline[31:0]=0xDEADBEEF, oaddr=0x400.
REQ-033 Write collision: during fill of 0x40, iwe to 0x4C=0xAAAAAAAA one cycle before its capture -> oline[127:96]=0xAAAAAAAA; same-edge write -> old value 0x44444444.
REQ-034 Abort: rst pulse after E2 of a fill -> no ovalid, oline=0; new ireq iaddr=0x40 -> normal line after 4 cycles.
